ram_loader: RTL

- Initiator-side block for the unified instruction/data RAM (word-addressed, 14-bit Address, 32-bit data, MemWrite strobe, synchronous read).
- Receives a program image as a byte stream, assembles 32-bit words and writes them into RAM sequentially.
- Then reads the image back, checksums it, and reports Done or Error.
- Sits between the host/UART byte source and the RAM port, ahead of the CPU, which is held off while Busy is high.

---
 rtl/ram_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Loads a length-prefixed little-endian byte stream into the word RAM, then reads
// the image back and compares its mod-2^32 sum with the trailing checksum.
module ram_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WORDS  = 8192
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  MemWrite,
    output logic [31:0]           WriteData,
    input  logic [31:0]           ReadData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH:0]   WordCount
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_VERIFY, S_DONE, S_ERROR
    } state_t;

    state_t             state;
    logic [7:0]         lenLo;
    logic [CNT_W-1:0]   wordTotal;
    logic [23:0]        byteAcc;
    logic [1:0]         byteIdx;
    logic [31:0]        expectedSum;
    logic [31:0]        readSum;
    logic [CNT_W-1:0]   verifyCnt;

    logic               byteFire;
    logic [15:0]        lenFull;
    logic [31:0]        fullWord;
    logic [31:0]        sumNext;
    logic [CNT_W-1:0]   nextCnt;

    assign ByteReady = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CSUM);
    assign byteFire  = ByteValid && ByteReady;
    assign lenFull   = {ByteIn, lenLo};
    // Bytes shift in from the top, so after three bytes byteAcc holds {b2,b1,b0}.
    assign fullWord  = {ByteIn, byteAcc};
    assign sumNext   = readSum + ReadData;
    assign nextCnt   = verifyCnt + 1'b1;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            lenLo       <= '0;
            wordTotal   <= '0;
            byteAcc     <= '0;
            byteIdx     <= '0;
            expectedSum <= '0;
            readSum     <= '0;
            verifyCnt   <= '0;
            Address     <= '0;
            MemWrite    <= 1'b0;
            WriteData   <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
            WordCount   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (Start) begin
                        state       <= S_LEN0;
                        Busy        <= 1'b1;
                        Done        <= 1'b0;
                        Error       <= 1'b0;
                        WordCount   <= '0;
                        readSum     <= '0;
                        expectedSum <= '0;
                        byteIdx     <= '0;
                    end
                end
                S_LEN0: begin
                    if (byteFire) begin
                        lenLo <= ByteIn;
                        state <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (byteFire) begin
                        wordTotal <= CNT_W'(lenFull);
                        if (32'(lenFull) > MAX_WORDS) begin
                            state <= S_ERROR;
                            Busy  <= 1'b0;
                            Error <= 1'b1;
                        end else if (lenFull == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (byteFire) begin
                        byteAcc <= {ByteIn, byteAcc[23:8]};
                        byteIdx <= byteIdx + 1'b1;
                        if (byteIdx == 2'd3) begin
                            MemWrite  <= 1'b1;
                            Address   <= WordCount[ADDR_WIDTH-1:0];
                            WriteData <= fullWord;
                            WordCount <= WordCount + 1'b1;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    MemWrite <= 1'b0;
                    state    <= (WordCount < wordTotal) ? S_DATA : S_CSUM;
                end
                S_CSUM: begin
                    if (byteFire) begin
                        byteAcc <= {ByteIn, byteAcc[23:8]};
                        byteIdx <= byteIdx + 1'b1;
                        if (byteIdx == 2'd3) begin
                            expectedSum <= fullWord;
                            if (wordTotal != '0) begin
                                state     <= S_VERIFY;
                                Address   <= '0;
                                verifyCnt <= '0;
                            end else if (fullWord == 32'd0) begin
                                state <= S_DONE;
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                            end else begin
                                state <= S_ERROR;
                                Busy  <= 1'b0;
                                Error <= 1'b1;
                            end
                        end
                    end
                end
                S_VERIFY: begin
                    // ReadData trails Address by one cycle, so the sum lags the address counter.
                    if (verifyCnt != '0) readSum <= sumNext;
                    if (nextCnt < wordTotal) Address <= nextCnt[ADDR_WIDTH-1:0];
                    verifyCnt <= nextCnt;
                    if (verifyCnt == wordTotal) begin
                        Busy <= 1'b0;
                        if (sumNext == expectedSum) begin
                            state <= S_DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            Error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
